// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used by the cache arbiter slice.
// Holds the word/line types and the arbiter state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    s_idle,
    s_busy_i,
    s_busy_d
  } lc3b_arb_state;

  // Downstream memory works on 16-byte lines, so the byte offset is always zero.
  localparam lc3b_word LINE_MASK = 16'hFFF0;

endpackage

// File: rtl/arb_req_reg.sv
// Load-enabled holding register for the granted pmem request.
// Keeps the downstream strobes stable until the transaction completes.
module arb_req_reg
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_load,
  input  logic     i_clear,
  input  lc3b_word i_address,
  input  lc3b_line i_wdata,
  input  logic     i_read,
  input  logic     i_write,
  output lc3b_word o_address,
  output lc3b_line o_wdata,
  output logic     o_read,
  output logic     o_write
);

  lc3b_word r_address;
  lc3b_line r_wdata;
  logic     r_read;
  logic     r_write;

  // A request asserting both read and write is issued as a write only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_address <= '0;
      r_wdata   <= '0;
      r_read    <= 1'b0;
      r_write   <= 1'b0;
    end else if (i_load) begin
      r_address <= i_address & LINE_MASK;
      r_wdata   <= i_wdata;
      r_read    <= i_read & ~i_write;
      r_write   <= i_write;
    end else if (i_clear) begin
      r_read    <= 1'b0;
      r_write   <= 1'b0;
    end
  end

  assign o_address = r_address;
  assign o_wdata   = r_wdata;
  assign o_read    = r_read;
  assign o_write   = r_write;

endmodule

// File: rtl/cache_arbiter.sv
// Shares the physical-memory port between the L1 icache and dcache.
// One grant at a time; the response is routed only to the granted cache.
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int PRIORITY_MODE = 0,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 icache_pmem_read,
  input  logic                 icache_pmem_write,
  input  logic [15:0]          icache_pmem_address,
  input  logic [127:0]         icache_pmem_wdata,
  output logic [127:0]         icache_pmem_rdata,
  output logic                 icache_pmem_resp,
  input  logic                 dcache_pmem_read,
  input  logic                 dcache_pmem_write,
  input  logic [15:0]          dcache_pmem_address,
  input  logic [127:0]         dcache_pmem_wdata,
  output logic [127:0]         dcache_pmem_rdata,
  output logic                 dcache_pmem_resp,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [15:0]          mem_address,
  output logic [127:0]         mem_wdata,
  input  logic [127:0]         mem_rdata,
  input  logic                 mem_resp,
  output logic [CNT_WIDTH-1:0] contention_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  lc3b_arb_state        r_state;
  lc3b_arb_state        w_nextState;
  logic                 r_lastGrant;
  logic                 w_nextLastGrant;
  logic [CNT_WIDTH-1:0] r_count;

  logic     w_iPend;
  logic     w_dPend;
  logic     w_grantD;
  logic     w_load;
  logic     w_clear;
  logic     w_contend;
  lc3b_word w_reqAddress;
  lc3b_line w_reqWdata;
  logic     w_reqRead;
  logic     w_reqWrite;

  assign w_iPend   = icache_pmem_read | icache_pmem_write;
  assign w_dPend   = dcache_pmem_read | dcache_pmem_write;
  assign w_contend = (r_state == s_idle) & w_iPend & w_dPend;

  // r_lastGrant: 0 = icache, 1 = dcache; round-robin picks the other one.
  always_comb begin
    w_grantD = w_dPend;
    if (w_iPend && w_dPend) begin
      w_grantD = (PRIORITY_MODE != 0) ? 1'b1 : ~r_lastGrant;
    end
  end

  assign w_reqAddress = w_grantD ? dcache_pmem_address : icache_pmem_address;
  assign w_reqWdata   = w_grantD ? dcache_pmem_wdata   : icache_pmem_wdata;
  assign w_reqRead    = w_grantD ? dcache_pmem_read    : icache_pmem_read;
  assign w_reqWrite   = w_grantD ? dcache_pmem_write   : icache_pmem_write;

  always_comb begin
    w_nextState      = r_state;
    w_nextLastGrant  = r_lastGrant;
    w_load           = 1'b0;
    w_clear          = 1'b0;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;
    unique case (r_state)
      s_idle: begin
        if (w_iPend || w_dPend) begin
          w_load          = 1'b1;
          w_nextLastGrant = w_grantD;
          w_nextState     = w_grantD ? s_busy_d : s_busy_i;
        end
      end
      s_busy_i: begin
        if (mem_resp) begin
          icache_pmem_resp = 1'b1;
          w_clear          = 1'b1;
          w_nextState      = s_idle;
        end
      end
      s_busy_d: begin
        if (mem_resp) begin
          dcache_pmem_resp = 1'b1;
          w_clear          = 1'b1;
          w_nextState      = s_idle;
        end
      end
      default: w_nextState = s_idle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= s_idle;
      r_lastGrant <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_lastGrant <= w_nextLastGrant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_contend && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_ONE;
    end
  end

  arb_req_reg u_reqReg (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_clear   (w_clear),
    .i_address (w_reqAddress),
    .i_wdata   (w_reqWdata),
    .i_read    (w_reqRead),
    .i_write   (w_reqWrite),
    .o_address (mem_address),
    .o_wdata   (mem_wdata),
    .o_read    (mem_read),
    .o_write   (mem_write)
  );

  assign icache_pmem_rdata = mem_rdata;
  assign dcache_pmem_rdata = mem_rdata;
  assign contention_count  = r_count;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: two instances (round-robin/16-bit counter
// and dcache-priority/4-bit counter) each driven by random cache traffic.
module tb_cache_arbiter;

  typedef struct {
    bit           isD;
    bit           isWrite;
    logic [15:0]  addr;
    logic [127:0] wdata;
    int           count;
  } txn_t;

  typedef struct {
    bit           isD;
    logic [127:0] rdata;
  } resp_t;

  typedef struct {
    bit           rd;
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit doneA = 1'b0;
  bit doneB = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic failBound(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got bound expired, expected completion", name);
  endtask

  function automatic logic [127:0] randLine();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic req_t mkReq(input bit rd, input bit wr, input logic [15:0] addr, input logic [127:0] wdata);
    req_t r;
    r.rd    = rd;
    r.wr    = wr;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

  function automatic req_t randReq();
    req_t r;
    int   k;
    k       = $urandom_range(0, 7);
    r.rd    = (k < 5) || (k == 7);
    r.wr    = (k >= 5);
    r.addr  = 16'($urandom);
    r.wdata = randLine();
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int PM   = g;
    localparam int CW   = (g == 0) ? 16 : 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          rst;
    logic          iRead, iWrite, dRead, dWrite;
    logic [15:0]   iAddr, dAddr;
    logic [127:0]  iWdata, dWdata, iRdata, dRdata;
    logic          iResp, dResp;
    logic          memRead, memWrite, memResp;
    logic [15:0]   memAddress;
    logic [127:0]  memWdata, memRdata;
    logic [CW-1:0] count;

    cache_arbiter #(.PRIORITY_MODE(PM), .CNT_WIDTH(CW)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .icache_pmem_read    (iRead),
      .icache_pmem_write   (iWrite),
      .icache_pmem_address (iAddr),
      .icache_pmem_wdata   (iWdata),
      .icache_pmem_rdata   (iRdata),
      .icache_pmem_resp    (iResp),
      .dcache_pmem_read    (dRead),
      .dcache_pmem_write   (dWrite),
      .dcache_pmem_address (dAddr),
      .dcache_pmem_wdata   (dWdata),
      .dcache_pmem_rdata   (dRdata),
      .dcache_pmem_resp    (dResp),
      .mem_read            (memRead),
      .mem_write           (memWrite),
      .mem_address         (memAddress),
      .mem_wdata           (memWdata),
      .mem_rdata           (memRdata),
      .mem_resp            (memResp),
      .contention_count    (count)
    );

    txn_t  txnQ[$];
    resp_t respQ[$];
    req_t  iScript[$];
    req_t  dScript[$];
    req_t  iCur, dCur;
    bit    iPend, dPend, iDone, dDone;
    bit    monOn, issueOn;
    // Reference model: who owns the port (0 none, 1 icache, 2 dcache),
    // cycles left until memory answers, last winner, contended arbitrations.
    int    mOwner, mRemain, mCount, mTxns;
    bit    mLast;

    function automatic string nm(input string s);
      return $sformatf("m%0d %s", g, s);
    endfunction

    task automatic resetModel();
      mOwner  = 0;
      mRemain = 0;
      mCount  = 0;
      mLast   = 1'b0;
      iPend   = 1'b0;
      dPend   = 1'b0;
      iDone   = 1'b0;
      dDone   = 1'b0;
      txnQ.delete();
      respQ.delete();
      iScript.delete();
      dScript.delete();
    endtask

    task automatic driveCaches();
      iRead  = iPend & iCur.rd;
      iWrite = iPend & iCur.wr;
      iAddr  = iCur.addr;
      iWdata = iCur.wdata;
      dRead  = dPend & dCur.rd;
      dWrite = dPend & dCur.wr;
      dAddr  = dCur.addr;
      dWdata = dCur.wdata;
    endtask

    // One cycle: update cache requesters, play memory, and predict the arbiter.
    task automatic applyStimulus();
      txn_t  t;
      resp_t r;
      bit    winD;
      memResp  = 1'b0;
      memRdata = randLine();
      if (iDone) begin iPend = 1'b0; iDone = 1'b0; end
      if (dDone) begin dPend = 1'b0; dDone = 1'b0; end
      if (!iPend) begin
        if (iScript.size() > 0) begin iCur = iScript.pop_front(); iPend = 1'b1; end
        else if (issueOn && $urandom_range(0, 3) != 0) begin iCur = randReq(); iPend = 1'b1; end
      end else if ($urandom_range(0, 3) == 0) begin
        iCur.addr  = 16'($urandom);
        iCur.wdata = randLine();
      end
      if (!dPend) begin
        if (dScript.size() > 0) begin dCur = dScript.pop_front(); dPend = 1'b1; end
        else if (issueOn && $urandom_range(0, 3) != 0) begin dCur = randReq(); dPend = 1'b1; end
      end else if ($urandom_range(0, 3) == 0) begin
        dCur.addr  = 16'($urandom);
        dCur.wdata = randLine();
      end
      driveCaches();
      if (mOwner == 0) begin
        if (iPend || dPend) begin
          winD = dPend;
          if (iPend && dPend) begin
            if (mCount < CMAX) mCount++;
            winD = (PM != 0) ? 1'b1 : !mLast;
          end
          mLast     = winD;
          t.isD     = winD;
          t.isWrite = winD ? dCur.wr : iCur.wr;
          t.addr    = (winD ? dCur.addr : iCur.addr) & 16'hFFF0;
          t.wdata   = winD ? dCur.wdata : iCur.wdata;
          t.count   = mCount;
          txnQ.push_back(t);
          mOwner  = winD ? 2 : 1;
          mRemain = (mTxns == 0) ? 3 : $urandom_range(1, 4);
          mTxns++;
        end
      end else begin
        mRemain--;
        if (mRemain == 0) begin
          memResp = 1'b1;
          r.isD   = (mOwner == 2);
          r.rdata = memRdata;
          respQ.push_back(r);
          if (r.isD) dDone = 1'b1; else iDone = 1'b1;
          mOwner = 0;
        end
      end
    endtask

    task automatic runUntilIdle(input int limit, input string tag);
      for (int i = 0; i < limit; i++) begin
        @(negedge clk);
        applyStimulus();
        if (mOwner == 0 && !iPend && !dPend && iScript.size() == 0 && dScript.size() == 0) return;
      end
      failBound(nm(tag));
    endtask

    initial begin
      bit found;
      rst     = 1'b1;
      monOn   = 1'b0;
      issueOn = 1'b0;
      mTxns   = 0;
      memResp = 1'b0;
      memRdata = '0;
      iCur = mkReq(0, 0, 16'h0, '0);
      dCur = mkReq(0, 0, 16'h0, '0);
      resetModel();
      driveCaches();
      repeat (2) @(negedge clk);
      #1;
      checkOutput(nm("reset mem_read"), memRead, 0);
      checkOutput(nm("reset mem_write"), memWrite, 0);
      checkOutput(nm("reset count"), count, 0);
      checkOutput(nm("reset resps"), {iResp, dResp}, 0);
      @(negedge clk);
      rst   = 1'b0;
      monOn = 1'b1;

      iScript.push_back(mkReq(1, 0, 16'h1234, '0));
      runUntilIdle(50, "lone icache read");

      dScript.push_back(mkReq(0, 1, 16'h4A00, randLine()));
      dScript.push_back(mkReq(1, 0, 16'h6A00, '0));
      runUntilIdle(50, "dcache write then read");

      issueOn = 1'b1;
      repeat (400) begin
        @(negedge clk);
        applyStimulus();
      end

      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        applyStimulus();
        if (mOwner == 2) begin found = 1'b1; break; end
      end
      if (!found) begin
        failBound(nm("wait for dcache grant"));
      end else begin
        @(negedge clk);
        checkOutput(nm("strobe before reset"), memRead | memWrite, 1);
        monOn   = 1'b0;
        issueOn = 1'b0;
        rst     = 1'b1;
        resetModel();
        driveCaches();
        #1;
        checkOutput(nm("async reset mem_read"), memRead, 0);
        checkOutput(nm("async reset mem_write"), memWrite, 0);
        checkOutput(nm("async reset count"), count, 0);
        @(negedge clk);
        rst      = 1'b0;
        memResp  = 1'b1;
        memRdata = randLine();
        #1;
        checkOutput(nm("stale icache resp"), iResp, 0);
        checkOutput(nm("stale dcache resp"), dResp, 0);
        checkOutput(nm("stale strobe"), memRead | memWrite, 0);
        @(negedge clk);
        memResp = 1'b0;
        monOn   = 1'b1;
      end

      issueOn = 1'b1;
      repeat (150) begin
        @(negedge clk);
        applyStimulus();
      end
      issueOn = 1'b0;
      runUntilIdle(100, "final drain");
      @(negedge clk);
      #2;
      checkOutput(nm("txns left unissued"), txnQ.size(), 0);
      checkOutput(nm("resps left unseen"), respQ.size(), 0);
      if (g == 0) doneA = 1'b1; else doneB = 1'b1;
    end

    // Monitor: pops expectations when the DUT starts a transfer or answers a cache.
    initial begin
      bit    prevStrobe;
      bit    prevResp;
      bit    strobe;
      txn_t  t;
      resp_t r;
      prevStrobe = 1'b0;
      prevResp   = 1'b0;
      forever begin
        @(negedge clk);
        #1;
        if (!monOn) begin
          prevStrobe = 1'b0;
          prevResp   = 1'b0;
          continue;
        end
        strobe = memRead | memWrite;
        if (strobe && !prevStrobe) begin
          checkOutput(nm("grant expected"), txnQ.size(), 1);
          if (txnQ.size() > 0) begin
            t = txnQ.pop_front();
            checkOutput(nm("mem_address"), memAddress, t.addr);
            checkOutput(nm("mem_write"), memWrite, t.isWrite);
            checkOutput(nm("mem_read"), memRead, !t.isWrite);
            if (t.isWrite) checkOutput(nm("mem_wdata"), memWdata, t.wdata);
            checkOutput(nm("contention_count"), count, t.count);
          end
        end
        if (prevStrobe && !strobe && !prevResp) failBound(nm("strobe held until resp"));
        if (prevResp) checkOutput(nm("strobe after resp"), strobe, 0);
        if (respQ.size() > 0) begin
          r = respQ.pop_front();
          checkOutput(nm("icache resp"), iResp, !r.isD);
          checkOutput(nm("dcache resp"), dResp, r.isD);
          checkOutput(nm("icache rdata"), iRdata, r.rdata);
          checkOutput(nm("dcache rdata"), dRdata, r.rdata);
        end else if (iResp || dResp) begin
          checkOutput(nm("spurious resp"), {iResp, dResp}, 0);
        end
        prevResp   = iResp | dResp;
        prevStrobe = strobe;
      end
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(doneA && doneB) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (!(doneA && doneB)) failBound("bench completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
Shares one physical-memory port between the split L1 instruction cache and L1 data cache of the LC-3b pipeline. Each cache's control FSM drives line-sized pmem requests and holds them until it sees its own response. The arbiter grants one requester at a time and latches that request into registers for the downstream memory. It forwards the response only to the granted cache and counts contention cycles for performance analysis.

Parameters:
PRIORITY_MODE, 0, 0 = round-robin between icache and dcache; 1 = fixed priority to dcache
CNT_WIDTH, 16, width of the saturating contention counter

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  reset, asynchronous, active-high
icache_pmem_read  input  1  icache line-fill request
icache_pmem_write  input  1  icache writeback request (tied 0 in current design, supported anyway)
icache_pmem_address  input  16  icache line address, bits [3:0] don't-care
icache_pmem_wdata  input  128  icache writeback line
icache_pmem_rdata  output  128  line returned to icache
icache_pmem_resp  output  1  icache transaction complete
dcache_pmem_read  input  1  dcache line-fill request
dcache_pmem_write  input  1  dcache dirty-line writeback request
dcache_pmem_address  input  16  dcache line address
dcache_pmem_wdata  input  128  dcache writeback line
dcache_pmem_rdata  output  128  line returned to dcache
dcache_pmem_resp  output  1  dcache transaction complete
mem_read  output  1  downstream read strobe, registered
mem_write  output  1  downstream write strobe, registered
mem_address  output  16  downstream address, registered, low 4 bits forced 0
mem_wdata  output  128  downstream write line, registered
mem_rdata  input  128  downstream read line
mem_resp  input  1  downstream completion, one cycle pulse
contention_count  output  CNT_WIDTH  cycles in s_idle with both requesters pending, saturating

Behaviour:
- States: s_idle, s_busy_i, s_busy_d. On reset: s_idle, last_grant=0 (icache), all request registers 0, contention_count 0, mem_read, mem_write and both resp outputs 0.
- Reset is asynchronous. It takes effect mid-transaction, deasserts mem_read and mem_write immediately, and drops the grant.
- s_idle, no requests: stay. A requester is pending when read or write is asserted.
- s_idle, one requester pending: latch its address (low 4 bits zeroed), wdata and rw. Go to the matching busy state.
- s_idle, both pending: increment contention_count, holding at all-ones. PRIORITY_MODE=0 grants the requester != last_grant. PRIORITY_MODE=1 always grants dcache. last_grant updates to the winner.
- If a requester asserts read and write together, write wins and a write is issued.
- Busy states: mem_read/mem_write are driven from the latched registers and held until mem_resp. Requester inputs are ignored while busy, so later changes to a held request have no effect.
- Cycle with mem_resp=1 in a busy state: the granted cache's pmem_resp=1 in the same cycle (combinational). Next state is s_idle with mem_read/mem_write cleared.
- The ungranted cache's resp is 0 at all times.
- mem_rdata is passed straight through to both *_pmem_rdata. A cache may only sample it with its own resp.
- mem_resp while in s_idle (e.g. a stale response after reset) is ignored and not forwarded.
- Latency: request first seen in s_idle at cycle N → mem_read/write high from N+1. mem_resp at cycle M → requester resp at M. The next grant is evaluated at M+1, and downstream is reasserted at M+2.
- Back-to-back dcache writeback followed by fill is handled as two separate grants. In round-robin mode a pending icache request wins the slot between them.

Decomposition:
- Add to lc3b_types: lc3b_line (logic[127:0]) and lc3b_arb_state enum {s_idle, s_busy_i, s_busy_d}. lc3b_word is already present.
- One natural sub-module: arb_req_reg. It is the load-enabled register holding address/wdata/read/write, with asynchronous clear and low-nibble masking. It is instantiated once.
- Grant logic, FSM and counter stay in cache_arbiter.

Test Plan:
- Lone icache read of 0x1234 with mem_resp 3 cycles after mem_read → mem_address=0x1230, mem_read high for 3 cycles, icache_pmem_resp pulses once with rdata, dcache_pmem_resp stays 0.
- Both caches request reads continuously with PRIORITY_MODE=0 → grants alternate D,I,D,I (last_grant starts at 0), and contention_count increments by 1 per arbitration.
- PRIORITY_MODE=1 with both requesting → dcache is granted every arbitration and icache only when dcache is idle.
- dcache asserts write 0x4A00 then read 0x6A00, icache idle → two grants: mem_write with wdata first, then mem_read. Changing dcache inputs mid-write does not alter mem_address.
- rst asserted while s_busy_d → mem_read drops the same cycle. A subsequent mem_resp in s_idle produces no resp on either cache.
- Counter with CNT_WIDTH=4 and 20 contended arbitrations → contention_count saturates at 15.
